// File: rtl/lfsr_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_led_pkg
//  Description : Shared types and constants for the LED pattern sequencer:
//                pattern mode encoding and maximal-length Fibonacci tap
//                masks for common LED bank widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_led_pkg;

    // Pattern modes, encoded exactly as presented on mode_i.
    typedef enum logic [1:0] {
        MODE_LFSR = 2'b00,
        MODE_BIN  = 2'b01,
        MODE_GRAY = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // Maximal-length feedback masks; bit i set means data[i] enters the XOR.
    localparam logic [2:0] c_taps_w3 = 3'b110;        // x^3+x^2+1
    localparam logic [3:0] c_taps_w4 = 4'b1100;       // x^4+x^3+1
    localparam logic [4:0] c_taps_w5 = 5'b10100;      // x^5+x^3+1
    localparam logic [5:0] c_taps_w6 = 6'b110000;     // x^6+x^5+1
    localparam logic [6:0] c_taps_w7 = 7'b1100000;    // x^7+x^6+1
    localparam logic [7:0] c_taps_w8 = 8'b10111000;   // x^8+x^6+x^5+x^4+1

endpackage
`default_nettype wire

// File: rtl/lfsr_led_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running prescaler producing a one-cycle clock-enable
//                pulse in the cycle after the counter was all-ones. Holds
//                (and suppresses the pulse) while disabled; clear restarts
//                the count from zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int unsigned width_p = 22
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic en_i,
    input  logic clear_i,
    output logic tick_o
);

    logic [width_p-1:0] cnt_q;
    logic [width_p-1:0] cnt_d;
    logic               tick_q;
    logic               tick_d;

    // Next count and pulse: clear beats enable; pulse only when counting past all-ones.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d  = cnt_q + width_p'(1);
            tick_d = &cnt_q;
        end
    end

    // Prescaler and pulse registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_led_sequencer
//  Description : LED bank pattern generator. Advances on a prescaler tick or
//                a single-step rising edge, in LFSR, binary, Gray or hold
//                mode. A mode change reloads the seed and restarts the
//                prescaler, discarding any advance in that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_led_sequencer
    import lfsr_led_pkg::*;
#(
    parameter int unsigned         width_p          = 5,
    parameter int unsigned         prescale_width_p = 22,
    parameter logic [width_p-1:0]  taps_p           = 5'b10100,
    parameter logic [width_p-1:0]  seed_p           = 5'b00001
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [1:0]         mode_i,
    input  logic               pause_i,
    input  logic               step_i,
    output logic               tick_o,
    output logic [width_p-1:0] data_o
);

    mode_e              mode_q;
    mode_e              mode_d;
    logic               step_q;
    logic [width_p-1:0] state_q;
    logic [width_p-1:0] state_d;
    logic [width_p-1:0] data_q;
    logic [width_p-1:0] data_d;

    logic               w_mode_change;
    logic               w_step_rise;
    logic               w_adv;

    assign w_mode_change = (mode_i != mode_q);
    assign w_step_rise   = step_i & ~step_q;
    // A tick and a step edge together still count as a single advance.
    assign w_adv         = (tick_o | w_step_rise) & ~w_mode_change;

    tick_gen #(
        .width_p (prescale_width_p)
    ) u_tick_gen (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (~pause_i),
        .clear_i   (w_mode_change),
        .tick_o    (tick_o)
    );

    // Next pattern state: mode change reloads seed, otherwise advance per current mode.
    always_comb begin
        mode_d  = mode_q;
        state_d = state_q;
        if (w_mode_change) begin
            mode_d  = mode_e'(mode_i);
            state_d = seed_p;
        end else if (w_adv) begin
            case (mode_q)
                MODE_LFSR: begin
                    // An all-zero LFSR would never leave zero, so recover via the seed.
                    if (state_q == '0) begin
                        state_d = seed_p;
                    end else begin
                        state_d = {state_q[width_p-2:0], ^(state_q & taps_p)};
                    end
                end
                MODE_BIN:  state_d = state_q + width_p'(1);
                MODE_GRAY: state_d = state_q + width_p'(1);
                MODE_HOLD: state_d = state_q;
                default:   state_d = state_q;
            endcase
        end
        // Gray mode keeps a binary count internally and shows its Gray code.
        data_d = (mode_d == MODE_GRAY) ? (state_d ^ (state_d >> 1)) : state_d;
    end

    // Mode, step history, pattern state and registered output.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            mode_q  <= MODE_LFSR;
            step_q  <= 1'b0;
            state_q <= seed_p;
            data_q  <= seed_p;
        end else begin
            mode_q  <= mode_d;
            step_q  <= step_i;
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_led_sequencer
//  Description : Self-checking bench for lfsr_led_sequencer (width 5,
//                prescaler width 2). Directed scenarios followed by random
//                stimulus, all compared against a behavioural model that
//                tracks the number of advances since the last seed load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_led_sequencer;

    localparam int c_width = 5;
    localparam int c_period = 4;
    localparam int c_lfsr_len = 31;

    logic             clk;
    logic             reset_n;
    logic [1:0]       mode;
    logic             pause;
    logic             step;
    logic             tick;
    logic [c_width-1:0] data;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_cnt;
    bit m_tick;
    bit m_step_prev;
    int m_mode;
    int m_pos;
    int lfsr_seq [c_lfsr_len];

    lfsr_led_sequencer #(
        .width_p          (c_width),
        .prescale_width_p (2)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .mode_i    (mode),
        .pause_i   (pause),
        .step_i    (step),
        .tick_o    (tick),
        .data_o    (data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // x^5+x^3+1 Fibonacci step: new bit = b4 ^ b2 shifted in at the bottom.
    function automatic int poly_next(input int v);
        int fb;
        fb = ((v >> 4) ^ (v >> 2)) & 1;
        return ((v << 1) & 31) | fb;
    endfunction

    // Pattern expected after m_pos advances from the seed in the current mode.
    function automatic int model_data();
        int b;
        b = (1 + m_pos) % 32;
        case (m_mode)
            0:       return lfsr_seq[m_pos % c_lfsr_len];
            1:       return b;
            2:       return b ^ (b >> 1);
            default: return 1;
        endcase
    endfunction

    task automatic model_update();
        bit adv;
        if (!reset_n) begin
            m_cnt = 0; m_tick = 0; m_step_prev = 0; m_mode = 0; m_pos = 0;
        end else begin
            adv = m_tick || (step && !m_step_prev);
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode); m_pos = 0; m_cnt = 0; m_tick = 0;
            end else begin
                if (adv && m_mode != 3) m_pos++;
                if (pause) begin
                    m_tick = 0;
                end else begin
                    m_tick = (m_cnt == c_period - 1);
                    m_cnt  = (m_cnt + 1) % c_period;
                end
            end
            m_step_prev = step;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        chk("tick", {31'd0, tick}, {31'd0, m_tick});
        chk("data", {27'd0, data}, model_data());
    endtask

    task automatic wait_tick(output int n);
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < 40) begin
            cycle();
            n++;
            seen = tick;
        end
        chk("tick_seen", {31'd0, seen}, 1);
    endtask

    task automatic advance();
        int n;
        wait_tick(n);
        cycle();
    endtask

    initial begin
        int n;
        int d0;
        int ticks;
        int distinct;
        bit seen_val [32];
        bit reached;

        lfsr_seq[0] = 1;
        for (int i = 1; i < c_lfsr_len; i++) lfsr_seq[i] = poly_next(lfsr_seq[i-1]);

        reset_n = 0; mode = 2'b00; pause = 0; step = 0;

        // 1. Reset, first tick latency, first LFSR steps
        repeat (3) cycle();
        chk("reset_data", {27'd0, data}, 1);
        chk("reset_tick", {31'd0, tick}, 0);
        reset_n = 1;
        wait_tick(n);
        chk("first_tick_latency", n, 4);
        cycle(); chk("lfsr_1", {27'd0, data}, 5'b00010);
        advance(); chk("lfsr_2", {27'd0, data}, 5'b00100);
        advance(); chk("lfsr_3", {27'd0, data}, 5'b01001);

        // 2. Full LFSR period from the seed
        reset_n = 0; cycle(); reset_n = 1;
        for (int i = 0; i < 32; i++) seen_val[i] = 0;
        distinct = 0;
        for (int i = 0; i < c_lfsr_len; i++) begin
            advance();
            if (!seen_val[data]) distinct++;
            seen_val[data] = 1;
        end
        chk("lfsr_distinct", distinct, 31);
        chk("lfsr_zero_unseen", {31'd0, seen_val[0]}, 0);
        chk("lfsr_wrap", {27'd0, data}, 1);

        // 3. Binary count and wrap
        mode = 2'b01; cycle();
        chk("bin_seed", {27'd0, data}, 1);
        advance(); chk("bin_2", {27'd0, data}, 2);
        advance(); chk("bin_3", {27'd0, data}, 3);
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            advance();
            reached = (data == 5'b11111);
        end
        chk("bin_reach_max", {31'd0, reached}, 1);
        advance(); chk("bin_wrap", {27'd0, data}, 0);

        // 4. Gray count
        mode = 2'b10; cycle();
        chk("gray_1", {27'd0, data}, 5'b00001);
        advance(); chk("gray_2", {27'd0, data}, 5'b00011);
        advance(); chk("gray_3", {27'd0, data}, 5'b00010);

        // 5. Pause, held step, coincident step and tick
        mode = 2'b01; cycle();
        pause = 1; cycle();
        d0 = int'(data);
        ticks = 0;
        repeat (20) begin cycle(); if (tick) ticks++; end
        chk("pause_no_tick", ticks, 0);
        chk("pause_hold", {27'd0, data}, d0);
        step = 1; repeat (5) cycle(); step = 0; cycle();
        chk("step_held_once", {27'd0, data}, d0 + 1);
        pause = 0;
        wait_tick(n);
        d0 = int'(data);
        step = 1; cycle(); step = 0;
        chk("step_tick_once", {27'd0, data}, d0 + 1);
        cycle(); cycle();
        chk("step_tick_settled", {27'd0, data}, d0 + 1);

        // 6. Mode change on a tick, then reset mid-run
        wait_tick(n);
        mode = 2'b00; cycle();
        chk("modechg_seed", {27'd0, data}, 1);
        chk("modechg_tick", {31'd0, tick}, 0);
        wait_tick(n);
        chk("modechg_restart", n, 4);
        advance(); advance();
        reset_n = 0; cycle();
        chk("midrun_reset_data", {27'd0, data}, 1);
        chk("midrun_reset_tick", {31'd0, tick}, 0);
        reset_n = 1;

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            step = ($urandom_range(0, 3) == 0);
            reset_n = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
